// File: rtl/mode_ctrl_if.sv
// mode_ctrl_if: button pulses in, display/odometer control outputs back
interface mode_ctrl_if;
    logic        nTrip_pulse;
    logic        nMode_pulse;
    logic [1:0]  mode;
    logic        trip_clr;
    logic        setup;
    logic [1:0]  digit_sel;
    logic [15:0] edit_bcd;
    logic [15:0] circ_bcd;

    modport master (
        output nTrip_pulse, nMode_pulse,
        input  mode, trip_clr, setup, digit_sel, edit_bcd, circ_bcd
    );

    modport slave (
        input  nTrip_pulse, nMode_pulse,
        output mode, trip_clr, setup, digit_sel, edit_bcd, circ_bcd
    );
endinterface

// File: rtl/mode_ctrl.sv
// mode_ctrl: decodes trip/mode/combined presses into display mode, trip clear and circumference setup
module mode_ctrl #(
    parameter int          SETUP_TIMEOUT = 5000,
    parameter logic [15:0] DEFAULT_CIRC  = 16'h2136
) (
    input logic        clock,
    input logic        Rst,
    mode_ctrl_if.slave bus
);
    localparam int            CW   = $clog2(SETUP_TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(SETUP_TIMEOUT - 1);

    typedef enum logic {NORMAL, SETUP} state_t;

    state_t        r_state;
    logic [1:0]    r_prev;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_mode;
    logic          r_trip_clr;
    logic [1:0]    r_digit;
    logic [15:0]   r_edit;
    logic [15:0]   r_circ;

    logic [1:0] w_cur;
    logic       w_evt;
    logic       w_trip;
    logic       w_mode;
    logic       w_both;
    logic [3:0] w_shift;
    logic [3:0] w_dig;
    logic [3:0] w_dig_inc;

    assign w_cur     = {bus.nTrip_pulse, bus.nMode_pulse};
    assign w_evt     = (w_cur != 2'b11) && (r_prev == 2'b11);
    assign w_trip    = w_evt && (w_cur == 2'b01);
    assign w_mode    = w_evt && (w_cur == 2'b10);
    assign w_both    = w_evt && (w_cur == 2'b00);
    // digit 0 is the most significant nibble, so the bit offset is 4*(3-digit)
    assign w_shift   = {~r_digit, 2'b00};
    assign w_dig     = r_edit[w_shift +: 4];
    assign w_dig_inc = (w_dig == 4'd9) ? 4'd0 : w_dig + 4'd1;

    assign bus.mode      = r_mode;
    assign bus.trip_clr  = r_trip_clr;
    assign bus.setup     = (r_state == SETUP);
    assign bus.digit_sel = r_digit;
    assign bus.edit_bcd  = r_edit;
    assign bus.circ_bcd  = r_circ;

    // edge-detect presses, then run the normal/setup state machine on each event
    always_ff @(posedge clock or posedge Rst) begin
        if (Rst) begin
            r_state    <= NORMAL;
            r_prev     <= 2'b11;
            r_cnt      <= '0;
            r_mode     <= 2'd0;
            r_trip_clr <= 1'b0;
            r_digit    <= 2'd0;
            r_edit     <= DEFAULT_CIRC;
            r_circ     <= DEFAULT_CIRC;
        end else begin
            r_prev     <= w_cur;
            r_trip_clr <= 1'b0;
            if (r_state == NORMAL) begin
                if (w_trip) r_trip_clr <= 1'b1;
                if (w_mode) r_mode <= r_mode + 2'd1;
                if (w_both) begin
                    r_state <= SETUP;
                    r_edit  <= r_circ;
                    r_digit <= 2'd0;
                    r_cnt   <= '0;
                end
            end else begin
                r_cnt <= (w_evt || r_cnt == LAST) ? '0 : r_cnt + 1'b1;
                if (w_trip) r_edit[w_shift +: 4] <= w_dig_inc;
                if (w_mode) r_digit <= r_digit + 2'd1;
                if (w_both) begin
                    r_circ  <= r_edit;
                    r_state <= NORMAL;
                end else if (!w_evt && r_cnt == LAST) begin
                    r_state <= NORMAL;
                    r_edit  <= r_circ;
                end
            end
        end
    end
endmodule

// File: tb/tb_mode_ctrl.sv
// tb_mode_ctrl: table-driven vectors plus hand sequences for timeout and async reset
module tb_mode_ctrl;
    logic clock;
    logic Rst;
    int   n_chk;
    int   n_fail;

    mode_ctrl_if bus ();

    mode_ctrl #(.SETUP_TIMEOUT(8), .DEFAULT_CIRC(16'h2136)) dut (
        .clock (clock),
        .Rst   (Rst),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        nt;
        logic        nm;
        logic [1:0]  mode;
        logic        clr;
        logic        setup;
        logic [1:0]  dig;
        logic [15:0] edit;
        logic [15:0] circ;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic nt, input logic nm, input logic [1:0] m, input logic c,
                       input logic s, input logic [1:0] d, input logic [15:0] e, input logic [15:0] ci);
        vecs.push_back('{nt, nm, m, c, s, d, e, ci});
    endtask

    task automatic pair(input logic nt, input logic nm, input logic [1:0] m, input logic s,
                        input logic [1:0] d, input logic [15:0] e, input logic [15:0] ci);
        add(nt, nm, m, 1'b0, s, d, e, ci);
        add(1'b1, 1'b1, m, 1'b0, s, d, e, ci);
    endtask

    task automatic step(input logic nt, input logic nm);
        bus.nTrip_pulse = nt;
        bus.nMode_pulse = nm;
        @(posedge clock);
        #1;
    endtask

    task automatic press(input logic nt, input logic nm);
        step(nt, nm);
        step(1'b1, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mode"}, 16'(bus.mode), 16'd0);
        chk({tag, "_clr"}, 16'(bus.trip_clr), 16'd0);
        chk({tag, "_setup"}, 16'(bus.setup), 16'd0);
        chk({tag, "_dig"}, 16'(bus.digit_sel), 16'd0);
        chk({tag, "_edit"}, bus.edit_bcd, 16'h2136);
        chk({tag, "_circ"}, bus.circ_bcd, 16'h2136);
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        bus.nTrip_pulse = 1'b1;
        bus.nMode_pulse = 1'b1;
        @(posedge clock);
        #1;
        Rst = 1'b0;
        chk_reset("reset");
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        Rst    = 1'b1;
        bus.nTrip_pulse = 1'b1;
        bus.nMode_pulse = 1'b1;

        for (int i = 0; i < 5; i++) begin
            add(1'b1, 1'b0, 2'((i + 1) % 4), 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
            repeat (3) add(1'b1, 1'b1, 2'((i + 1) % 4), 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
        end
        add(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 16'h2136, 16'h2136);
        add(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
        add(1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 16'h2136, 16'h2136);
        repeat (3) add(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
        add(1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
        add(1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
        add(1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
        add(1'b1, 1'b1, 2'd2, 1'b0, 1'b0, 2'd0, 16'h2136, 16'h2136);
        pair(1'b0, 1'b0, 2'd2, 1'b1, 2'd0, 16'h2136, 16'h2136);
        pair(1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 16'h3136, 16'h2136);
        pair(1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 16'h4136, 16'h2136);
        pair(1'b0, 1'b1, 2'd2, 1'b1, 2'd0, 16'h5136, 16'h2136);
        pair(1'b1, 1'b0, 2'd2, 1'b1, 2'd1, 16'h5136, 16'h2136);
        for (int k = 2; k <= 9; k++)
            pair(1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 16'h5036 + 16'(k << 8), 16'h2136);
        pair(1'b0, 1'b1, 2'd2, 1'b1, 2'd1, 16'h5036, 16'h2136);
        pair(1'b0, 1'b0, 2'd2, 1'b0, 2'd1, 16'h5036, 16'h5036);

        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].nt, vecs[i].nm);
            chk($sformatf("v%0d_mode", i), 16'(bus.mode), 16'(vecs[i].mode));
            chk($sformatf("v%0d_clr", i), 16'(bus.trip_clr), 16'(vecs[i].clr));
            chk($sformatf("v%0d_setup", i), 16'(bus.setup), 16'(vecs[i].setup));
            chk($sformatf("v%0d_dig", i), 16'(bus.digit_sel), 16'(vecs[i].dig));
            chk($sformatf("v%0d_edit", i), bus.edit_bcd, vecs[i].edit);
            chk($sformatf("v%0d_circ", i), bus.circ_bcd, vecs[i].circ);
        end

        do_reset();
        press(1'b1, 1'b0);
        press(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("to_edit", bus.edit_bcd, 16'h3136);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b1);
            chk($sformatf("to_setup_%0d", k), 16'(bus.setup), (k < 8) ? 16'd1 : 16'd0);
            chk($sformatf("to_mode_%0d", k), 16'(bus.mode), 16'd1);
            chk($sformatf("to_clr_%0d", k), 16'(bus.trip_clr), 16'd0);
        end
        chk("to_circ", bus.circ_bcd, 16'h2136);

        step(1'b0, 1'b0);
        repeat (7) step(1'b1, 1'b1);
        chk("edge_pre_setup", 16'(bus.setup), 16'd1);
        step(1'b1, 1'b0);
        chk("edge_setup", 16'(bus.setup), 16'd1);
        chk("edge_dig", 16'(bus.digit_sel), 16'd1);
        repeat (4) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        chk("wrap_dig", 16'(bus.digit_sel), 16'd1);
        chk("wrap_setup", 16'(bus.setup), 16'd1);
        chk("wrap_mode", 16'(bus.mode), 16'd1);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        chk("commit_setup", 16'(bus.setup), 16'd0);
        chk("commit_circ", bus.circ_bcd, 16'h2136);

        step(1'b1, 1'b1);
        press(1'b0, 1'b0);
        repeat (7) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (8) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (6) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (3) press(1'b0, 1'b1);
        chk("nines_edit", bus.edit_bcd, 16'h9999);
        chk("nines_setup", 16'(bus.setup), 16'd1);
        #3;
        Rst = 1'b1;
        #1;
        chk_reset("async");
        @(posedge clock);
        #2;
        Rst = 1'b0;
        @(posedge clock);
        #1;
        chk_reset("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
